// File: rtl/pl_fetch_queue_if.sv
// Fetch-queue bus: text-memory request/response, redirect, and decode handshake.
interface pl_fetch_queue_if;
   logic        next_inst;
   logic [31:0] request_pc;
   logic        inst_available;
   logic [31:0] inst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        out_ready;

   // The fetch queue itself
   modport master (
      output next_inst, request_pc, out_valid, out_inst, out_pc,
      input  inst_available, inst, redirect, redirect_pc, out_ready
   );

   // Memory / decode / branch-resolution side
   modport slave (
      input  next_inst, request_pc, out_valid, out_inst, out_pc,
      output inst_available, inst, redirect, redirect_pc, out_ready
   );
endinterface

// File: rtl/pl_fetch_queue.sv
// Instruction fetch queue: one outstanding text-memory request at a time,
// responses buffered in a DEPTH-entry circular queue of {pc, inst} for decode.
module pl_fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic             clock,
   input  logic             reset,
   pl_fetch_queue_if.master bus
);
   localparam int unsigned   PW   = $clog2(DEPTH);
   localparam int unsigned   CW   = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   entry_t        ent_q [DEPTH];
   logic [0:0]    state;
   logic [31:0]   fetch_pc;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;

   logic issue;
   logic enq;
   logic pop;

   // Issue only from IDLE with room guaranteed for the response; a response
   // is taken only in WAIT, so a level still high from the previous answer
   // during the issue cycle is never mistaken for the new one.
   always_comb begin
      issue = 1'b0;
      enq   = 1'b0;
      pop   = 1'b0;
      issue = !reset && (state == S_IDLE) && !bus.redirect && (count < FULL);
      enq   = (state == S_WAIT) && bus.inst_available && !bus.redirect;
      pop   = (count != '0) && bus.out_ready;
   end

   assign bus.next_inst  = issue;
   assign bus.request_pc = fetch_pc;
   assign bus.out_valid  = (count != '0);
   assign bus.out_pc     = ent_q[rd_ptr].pc;
   assign bus.out_inst   = ent_q[rd_ptr].inst;

   // Entry storage; needs no reset since count gates visibility
   always_ff @(posedge clock) begin
      if (enq) ent_q[wr_ptr] <= '{pc: fetch_pc, inst: bus.inst};
   end

   // FSM, fetch PC and queue bookkeeping; redirect flushes everything and
   // abandons any in-flight response
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= S_IDLE;
         fetch_pc <= RESET_PC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else if (bus.redirect) begin
         state    <= S_IDLE;
         fetch_pc <= bus.redirect_pc;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         if (issue) begin
            state <= S_WAIT;
         end else if (enq) begin
            state    <= S_IDLE;
            fetch_pc <= fetch_pc + 32'd4;
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         if (enq) wr_ptr <= wr_ptr + PW'(1);
         case ({enq, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: tb/tb_pl_fetch_queue.sv
// Bench for pl_fetch_queue: directed scenarios then random traffic, each cycle
// checked against a queue-based model of the fetch/decode behaviour.
module tb_pl_fetch_queue;
   localparam int DEPTH = 4;

   logic clock;
   logic reset;
   pl_fetch_queue_if bus ();

   pl_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   // Reference model state
   ent_t        q[$];
   logic [31:0] fpc;
   logic        pending;
   // Memory model state
   logic        issued_prev;
   int          cnt;
   int          mem_lat;
   logic        mem_fixed;

   int n_cmp;
   int n_err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp)
      else begin
         n_err++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      fpc         = 32'h0;
      pending     = 1'b0;
      issued_prev = 1'b0;
      cnt         = 0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset      = 1'b1;
      bus.redirect = 1'b0;
      #1;
      chk("rst_next_inst_a", 32'(bus.next_inst), 32'h0);
      @(posedge clock);
      #1;
      chk("rst_next_inst_b", 32'(bus.next_inst), 32'h0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
      model_reset();
   endtask

   // One clock of traffic: memory reacts, inputs driven, outputs checked,
   // then the model advances as the rising edge will.
   task automatic step(input logic rd, input logic [31:0] rpc, input logic rdy);
      logic exp_ni;
      logic acc;
      ent_t e;
      @(negedge clock);
      reset = 1'b0;
      if (issued_prev) begin
         cnt = mem_lat;
         bus.inst_available = 1'b0;
      end
      if (cnt > 0) begin
         cnt--;
         if (cnt == 0) begin
            bus.inst_available = 1'b1;
            bus.inst = mem_fixed ? 32'h0000_0013 : $urandom;
         end
      end
      bus.redirect    = rd;
      bus.redirect_pc = rpc;
      bus.out_ready   = rdy;
      #1;
      exp_ni = !pending && !rd && (q.size() < DEPTH);
      chk("next_inst", 32'(bus.next_inst), 32'(exp_ni));
      if (exp_ni) chk("request_pc", bus.request_pc, fpc);
      chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
         chk("out_pc", bus.out_pc, q[0].pc);
         chk("out_inst", bus.out_inst, q[0].inst);
      end
      acc = pending && bus.inst_available && !rd;
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (rd) begin
         q.delete();
         fpc     = rpc;
         pending = 1'b0;
      end else begin
         if (acc) begin
            e.pc   = fpc;
            e.inst = bus.inst;
            q.push_back(e);
            fpc     = fpc + 32'd4;
            pending = 1'b0;
         end
         if (exp_ni) pending = 1'b1;
      end
      issued_prev = exp_ni;
   endtask

   initial begin
      int guard;
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      bus.inst_available = 1'b0;
      bus.inst        = 32'h0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'h0;
      bus.out_ready   = 1'b0;
      mem_lat   = 2;
      mem_fixed = 1'b0;
      model_reset();

      do_reset();

      // First fetch at RESET_PC answered two cycles later with 0x13
      mem_lat = 2; mem_fixed = 1'b1;
      repeat (6) step(1'b0, 32'h0, 1'b1);
      mem_fixed = 1'b0;

      // Decode stalled, single-cycle memory: queue fills and issue stops
      mem_lat = 1;
      repeat (14) step(1'b0, 32'h0, 1'b0);
      chk("full_out_valid", 32'(bus.out_valid), 32'h1);
      step(1'b0, 32'h0, 1'b1);
      repeat (4) step(1'b0, 32'h0, 1'b0);

      // Redirect during WAIT; stale answer lands in the re-issue cycle
      mem_lat = 2;
      guard = 0;
      while (!pending && guard < 20) begin step(1'b0, 32'h0, 1'b1); guard++; end
      chk("wait_reached_a", 32'(pending), 32'h1);
      step(1'b1, 32'h80, 1'b1);
      repeat (6) step(1'b0, 32'h0, 1'b1);

      // Redirect together with a pop while three entries are queued
      mem_lat = 1;
      guard = 0;
      while (q.size() != 3 && guard < 30) begin step(1'b0, 32'h0, 1'b0); guard++; end
      chk("three_queued", 32'(bus.out_valid), 32'h1);
      step(1'b1, 32'h200, 1'b1);
      repeat (5) step(1'b0, 32'h0, 1'b1);

      // Fetch PC wraps past the top of the address space
      step(1'b1, 32'hFFFF_FFFC, 1'b1);
      repeat (8) step(1'b0, 32'h0, 1'b0);
      repeat (6) step(1'b0, 32'h0, 1'b1);

      // Reset while a request is outstanding
      mem_lat = 3;
      guard = 0;
      while (!pending && guard < 20) begin step(1'b0, 32'h0, 1'b1); guard++; end
      chk("wait_reached_b", 32'(pending), 32'h1);
      do_reset();
      repeat (6) step(1'b0, 32'h0, 1'b1);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         mem_lat = int'($urandom_range(1, 4));
         step(($urandom % 16) == 0, {$urandom, 2'b00} >> 0, ($urandom % 3) != 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
